functional_unit_arbiter: RTL and testbench
==========================================

Name: functional_unit_arbiter

Overview:
Shares one registered combined functional unit (FU) among NUM_REQUESTERS independent requesters, e.g. the lanes of a multi-threaded PE. Each requester issues ops through a valid/ready request port and gets its result back on its own valid/ready response port. Round-robin grant, at most one issue per cycle. An in-flight tag pipeline routes each FU result to its originator's response register.

Parameters:
NUM_REQUESTERS, 4, number of requester ports (>=2).
FU_LATENCY, 1, cycles from FU input to fu_result (1 for the two-stage combined FU).

Ports:
clock  input  1  positive-edge clock.
reset  input  1  synchronous, active-high reset.
req_valid  input  NUM_REQUESTERS  per-requester request valid.
req_ready  output  NUM_REQUESTERS  per-requester grant/accept.
req_op  input  NUM_REQUESTERS x TIA_OP_WIDTH  op per requester.
req_operand_0/1/2  input  NUM_REQUESTERS x TIA_WORD_WIDTH each  operands per requester.
rsp_valid  output  NUM_REQUESTERS  result available.
rsp_ready  input  NUM_REQUESTERS  requester consumes result.
rsp_result  output  NUM_REQUESTERS x TIA_WORD_WIDTH  held result per requester.
fu_enable  output  1  FU enable.
fu_op  output  TIA_OP_WIDTH  op to FU.
fu_operand_0/1/2  output  TIA_WORD_WIDTH each  operands to FU.
fu_result  input  TIA_WORD_WIDTH  FU registered result.
idle  output  1  no op in flight and no rsp_valid set.

Behaviour:
- Reset: clock/reset as decided (reset synchronous, active-high; clock clock). rsp_valid=0, rsp_result=0, in-flight pipeline cleared, RR pointer=0, idle=1. fu_enable=0 during reset.
- busy[i] = (requester i has an op in the in-flight pipeline) OR rsp_valid[i]. Eligible[i] = req_valid[i] & ~busy[i].
- Grant: combinational. Pick the first eligible index scanning pointer, pointer+1, ... modulo NUM_REQUESTERS. req_ready is one-hot on the grant, else all zero. A transfer occurs when req_valid&req_ready.
- Pointer: on transfer, becomes (grant+1) mod NUM_REQUESTERS. Otherwise unchanged.
- FU drive: fu_enable=1 every non-reset cycle. On transfer, fu_op/operands = granted requester's fields. With no transfer, fu_op=TIA_OP_NOP and operands=0.
- In-flight pipeline: FU_LATENCY stages of {valid, index[$clog2(NUM_REQUESTERS)-1:0]}. It shifts every non-reset cycle and is loaded with {transfer, grant index}.
- Write-back: when the last stage is valid with index k, rsp_result[k] <= fu_result and rsp_valid[k] <= 1 at that edge.
- rsp_valid[k] clears on the edge where rsp_ready[k]=1. rsp_result holds its value until the next write-back.
- No overwrite is possible, because busy blocks re-issue. Same-cycle write-back to k and consume by k cannot occur for the same k.
- Timing (L=FU_LATENCY=1):
  - issue in cycle t; rsp_valid high from t+2;
  - if consumed in t+2, the same requester is eligible again in t+3;
  - aggregate throughput is 1 op/cycle when at least L+2 requesters are active.
- Requesters hold req_* stable while valid and not ready. The arbiter does not store request fields.
- Ops are opaque, including HALT and MAC. The operand_0 accumulator for MAC is the requester's responsibility.
- Reset mid-operation: in-flight results are discarded. The fu_result write-back on the reset edge is suppressed.
- idle = ~|in-flight valids & ~|rsp_valid.

Decomposition:
- Shared package (datapath.svh): TIA_WORD_WIDTH, TIA_OP_WIDTH, TIA_OP_NOP. Add a typedef for the in-flight tag struct {valid, index}.
- Sub-module round_robin_arbiter, parameterised by NUM_REQUESTERS. It takes an eligible vector, outputs a one-hot grant and binary index, and owns the pointer register with an advance input.

Test Plan:
- Single requester 0: ADD operands 3,4, rsp_ready=1 → req_ready[0]=1 in cycle 0; fu_op=ADD in cycle 0; rsp_valid[0]=1 with rsp_result=7 in cycle 2, cleared in cycle 3.
- All four requesters valid continuously (SUB 10,i), rsp_ready=1 → grants 0,1,2,3,0,... one per cycle; each rsp_result[i]=10-i; no requester is granted while busy.
- Requester 2 rsp_ready=0 for 5 cycles after a result → rsp_valid[2] and rsp_result[2] stay stable; req_ready[2] stays 0 while others are still granted; requester 2 is re-granted the cycle after consumption.
- Simultaneous requests from 1 and 3 with pointer=2 → 3 granted first, pointer becomes 0, then 1 granted next cycle.
- Reset asserted the cycle after issuing LMUL 6,7 from requester 1 → rsp_valid stays 0; idle=1 after reset; pointer=0; fu_op=NOP with no requests.
- No requests for 10 cycles → req_ready=0, fu_op=NOP, operands=0, idle=1.

Source files
------------

// File: rtl/functional_unit_arbiter_pkg.sv
// Shared datapath definitions for the functional-unit arbiter slice.
//   TIA_WORD_WIDTH / TIA_OP_WIDTH : operand/result and opcode widths
//   TIA_OP_*                      : opcode encodings (opaque to the arbiter)
//   inflight_tag_t                : {valid, index} tag carried alongside an FU op
package functional_unit_arbiter_pkg;

    localparam int unsigned TIA_WORD_WIDTH  = 32;
    localparam int unsigned TIA_OP_WIDTH    = 5;
    // Tag index is sized for up to 256 requesters; the top uses the low bits.
    localparam int unsigned TAG_INDEX_WIDTH = 8;

    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_NOP  = TIA_OP_WIDTH'(0);
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_ADD  = TIA_OP_WIDTH'(1);
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_SUB  = TIA_OP_WIDTH'(2);
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_LMUL = TIA_OP_WIDTH'(3);

    typedef struct packed {
        logic                       valid;
        logic [TAG_INDEX_WIDTH-1:0] index;
    } inflight_tag_t;

endpackage

// File: rtl/functional_unit_arbiter_round_robin.sv
// Round-robin arbiter with an internal rotating priority pointer.
//   clock, reset : positive-edge clock, synchronous active-high reset
//   eligible     : per-requester candidate vector
//   advance      : a grant was accepted this cycle; rotate past it
//   grant        : one-hot grant (combinational)
//   grant_index  : binary index of the grant (combinational)
//   grant_valid  : some requester is granted (combinational)
module functional_unit_arbiter_round_robin #(
    parameter  int unsigned NUM_REQUESTERS = 4,
    localparam int unsigned INDEX_WIDTH    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] eligible,
    input  logic                      advance,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic [INDEX_WIDTH-1:0]    grant_index,
    output logic                      grant_valid
);

    logic [INDEX_WIDTH-1:0] pointer;
    int unsigned            candidate;
    logic [INDEX_WIDTH-1:0] candidate_index;

    // Scan pointer, pointer+1, ... modulo N and take the first eligible requester.
    always_comb begin
        grant           = '0;
        grant_index     = '0;
        grant_valid     = 1'b0;
        candidate       = 0;
        candidate_index = '0;
        for (int unsigned offset = 0; offset < NUM_REQUESTERS; offset++) begin
            candidate       = (32'(pointer) + offset) % NUM_REQUESTERS;
            candidate_index = INDEX_WIDTH'(candidate);
            if (!grant_valid && eligible[candidate_index]) begin
                grant_valid = 1'b1;
                grant_index = candidate_index;
            end
        end
        if (grant_valid) begin
            grant[grant_index] = 1'b1;
        end
    end

    // Priority moves to the requester just after the one that was served.
    always_ff @(posedge clock) begin
        if (reset) begin
            pointer <= '0;
        end else if (advance && grant_valid) begin
            pointer <= (grant_index == INDEX_WIDTH'(NUM_REQUESTERS - 1))
                       ? '0 : grant_index + INDEX_WIDTH'(1);
        end
    end

endmodule

// File: rtl/functional_unit_arbiter.sv
// Shares one registered functional unit among NUM_REQUESTERS requesters.
//   clock, reset                 : positive-edge clock, synchronous active-high reset
//   req_valid/req_ready          : per-requester issue handshake (ready = grant)
//   req_op, req_operand_0/1/2    : per-requester op fields, held by requester until accepted
//   rsp_valid/rsp_ready          : per-requester result handshake
//   rsp_result                   : per-requester held result
//   fu_enable, fu_op, fu_operand_0/1/2 : drive to the shared FU (NOP when nothing issues)
//   fu_result                    : FU result, FU_LATENCY cycles after issue
//   idle                         : nothing in flight and no result pending
module functional_unit_arbiter
    import functional_unit_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned FU_LATENCY     = 1
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUM_REQUESTERS-1:0]                     req_valid,
    output logic [NUM_REQUESTERS-1:0]                     req_ready,
    input  logic [NUM_REQUESTERS-1:0][TIA_OP_WIDTH-1:0]   req_op,
    input  logic [NUM_REQUESTERS-1:0][TIA_WORD_WIDTH-1:0] req_operand_0,
    input  logic [NUM_REQUESTERS-1:0][TIA_WORD_WIDTH-1:0] req_operand_1,
    input  logic [NUM_REQUESTERS-1:0][TIA_WORD_WIDTH-1:0] req_operand_2,
    output logic [NUM_REQUESTERS-1:0]                     rsp_valid,
    input  logic [NUM_REQUESTERS-1:0]                     rsp_ready,
    output logic [NUM_REQUESTERS-1:0][TIA_WORD_WIDTH-1:0] rsp_result,
    output logic                                          fu_enable,
    output logic [TIA_OP_WIDTH-1:0]                       fu_op,
    output logic [TIA_WORD_WIDTH-1:0]                     fu_operand_0,
    output logic [TIA_WORD_WIDTH-1:0]                     fu_operand_1,
    output logic [TIA_WORD_WIDTH-1:0]                     fu_operand_2,
    input  logic [TIA_WORD_WIDTH-1:0]                     fu_result,
    output logic                                          idle
);

    localparam int unsigned INDEX_WIDTH = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    logic [NUM_REQUESTERS-1:0] busy;
    logic [NUM_REQUESTERS-1:0] eligible;
    logic [NUM_REQUESTERS-1:0] grant;
    logic [INDEX_WIDTH-1:0]    grant_index;
    logic                      grant_valid;
    logic                      transfer;
    logic                      any_inflight;
    inflight_tag_t             tag_pipe [FU_LATENCY];
    inflight_tag_t             last_tag;

    // A requester is busy from issue until its result is consumed, so it can never be overwritten.
    always_comb begin
        busy = rsp_valid;
        for (int unsigned s = 0; s < FU_LATENCY; s++) begin
            if (tag_pipe[s].valid) begin
                busy[tag_pipe[s].index[INDEX_WIDTH-1:0]] = 1'b1;
            end
        end
    end

    assign eligible = req_valid & ~busy;

    functional_unit_arbiter_round_robin #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_round_robin (
        .clock      (clock),
        .reset      (reset),
        .eligible   (eligible),
        .advance    (transfer),
        .grant      (grant),
        .grant_index(grant_index),
        .grant_valid(grant_valid)
    );

    // No issue is accepted while reset is held.
    assign transfer  = grant_valid & ~reset;
    assign req_ready = transfer ? grant : '0;
    assign fu_enable = ~reset;

    // FU input mux: granted requester's fields, otherwise a NOP with zero operands.
    always_comb begin
        fu_op        = TIA_OP_NOP;
        fu_operand_0 = '0;
        fu_operand_1 = '0;
        fu_operand_2 = '0;
        if (transfer) begin
            fu_op        = req_op[grant_index];
            fu_operand_0 = req_operand_0[grant_index];
            fu_operand_1 = req_operand_1[grant_index];
            fu_operand_2 = req_operand_2[grant_index];
        end
    end

    // Tag pipeline tracks which requester owns each op inside the FU.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned s = 0; s < FU_LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: transfer, index: TAG_INDEX_WIDTH'(grant_index)};
            for (int unsigned s = 1; s < FU_LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign last_tag = tag_pipe[FU_LATENCY-1];

    // Write-back to the tagged requester; otherwise a consume clears the valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
                if (last_tag.valid && (last_tag.index == TAG_INDEX_WIDTH'(k))) begin
                    rsp_valid[k]  <= 1'b1;
                    rsp_result[k] <= fu_result;
                end else if (rsp_ready[k]) begin
                    rsp_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        any_inflight = 1'b0;
        for (int unsigned s = 0; s < FU_LATENCY; s++) begin
            any_inflight = any_inflight | tag_pipe[s].valid;
        end
        idle = ~any_inflight & ~(|rsp_valid);
    end

endmodule

// File: tb/tb_functional_unit_arbiter.sv
// Scoreboard bench for functional_unit_arbiter: a monitor records every grant,
// pushes the test's hand-computed result for that requester and pops it when
// the requester consumes its response.
module tb_functional_unit_arbiter;
    import functional_unit_arbiter_pkg::*;

    localparam int unsigned N = 4;

    logic                               clock;
    logic                               reset;
    logic [N-1:0]                       req_valid;
    logic [N-1:0]                       req_ready;
    logic [N-1:0][TIA_OP_WIDTH-1:0]     req_op;
    logic [N-1:0][TIA_WORD_WIDTH-1:0]   req_operand_0;
    logic [N-1:0][TIA_WORD_WIDTH-1:0]   req_operand_1;
    logic [N-1:0][TIA_WORD_WIDTH-1:0]   req_operand_2;
    logic [N-1:0]                       rsp_valid;
    logic [N-1:0]                       rsp_ready;
    logic [N-1:0][TIA_WORD_WIDTH-1:0]   rsp_result;
    logic                               fu_enable;
    logic [TIA_OP_WIDTH-1:0]            fu_op;
    logic [TIA_WORD_WIDTH-1:0]          fu_operand_0;
    logic [TIA_WORD_WIDTH-1:0]          fu_operand_1;
    logic [TIA_WORD_WIDTH-1:0]          fu_operand_2;
    logic [TIA_WORD_WIDTH-1:0]          fu_result;
    logic                               idle;

    functional_unit_arbiter #(.NUM_REQUESTERS(N), .FU_LATENCY(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_operand_0(req_operand_0),
        .req_operand_1(req_operand_1),
        .req_operand_2(req_operand_2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .fu_enable    (fu_enable),
        .fu_op        (fu_op),
        .fu_operand_0 (fu_operand_0),
        .fu_operand_1 (fu_operand_1),
        .fu_operand_2 (fu_operand_2),
        .fu_result    (fu_result),
        .idle         (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle registered FU model.
    always @(posedge clock) begin
        case (fu_op)
            TIA_OP_ADD:  fu_result <= fu_operand_0 + fu_operand_1;
            TIA_OP_SUB:  fu_result <= fu_operand_0 - fu_operand_1;
            TIA_OP_LMUL: fu_result <= fu_operand_0 * fu_operand_1;
            default:     fu_result <= '0;
        endcase
    end

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] value;
    } sb_entry_t;

    sb_entry_t   sb [$];
    int          gq [$];
    logic [31:0] exp_value [N];
    int          outstanding [N];
    int          total = 0;
    int          bad   = 0;
    int          found;
    int          exp_grant;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: grants feed the scoreboard, consumes drain it.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            for (int k = 0; k < N; k++) outstanding[k] = 0;
        end else begin
            check("fu_enable", 32'(fu_enable), 32'd1);
            if (req_ready != '0) begin
                check("grant_onehot", 32'($countones(req_ready)), 32'd1);
                for (int k = 0; k < N; k++) begin
                    if (req_valid[k] && req_ready[k]) begin
                        check("grant_while_busy", 32'(outstanding[k]), 32'd0);
                        check("fu_op", 32'(fu_op), 32'(req_op[k]));
                        check("fu_operand_0", fu_operand_0, req_operand_0[k]);
                        check("fu_operand_1", fu_operand_1, req_operand_1[k]);
                        if (gq.size() > 0) begin
                            exp_grant = gq.pop_front();
                            check("grant_order", 32'(k), 32'(exp_grant));
                        end
                        sb.push_back('{idx: 2'(k), value: exp_value[k]});
                        outstanding[k]++;
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (rsp_valid[k] && rsp_ready[k]) begin
                    found = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (found < 0 && sb[i].idx == 2'(k)) found = i;
                    end
                    total++;
                    if (found < 0) begin
                        bad++;
                        $display("FAIL unexpected_rsp: requester %0d result %0d with nothing expected", k, rsp_result[k]);
                    end else begin
                        total--;
                        check("rsp_result", rsp_result[k], sb[found].value);
                        sb.delete(found);
                        outstanding[k]--;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        @(negedge clock);
        check("fu_enable_in_reset", 32'(fu_enable), 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!idle && n < budget);
        check("idle_reached", 32'(idle), 32'd1);
        next_cycle();
    endtask

    task automatic set_req(input int k, input logic [TIA_OP_WIDTH-1:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        req_op[k]        = op;
        req_operand_0[k] = a;
        req_operand_1[k] = b;
        req_operand_2[k] = 32'd0;
        exp_value[k]     = expv;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        req_valid     = '0;
        req_op        = '0;
        req_operand_0 = '0;
        req_operand_1 = '0;
        req_operand_2 = '0;
        rsp_ready     = '1;
        for (int k = 0; k < N; k++) exp_value[k] = 32'd0;

        // Reset state
        do_reset();
        @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result_zero", 32'(rsp_result == '0), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_fu_op", 32'(fu_op), 32'(TIA_OP_NOP));
        next_cycle();

        // Single requester 0: ADD 3,4
        set_req(0, TIA_OP_ADD, 32'd3, 32'd4, 32'd7);
        req_valid = 4'b0001;
        @(negedge clock);
        check("t1_req_ready_c0", 32'(req_ready), 32'b0001);
        check("t1_fu_op_c0", 32'(fu_op), 32'(TIA_OP_ADD));
        next_cycle();
        req_valid = '0;
        @(negedge clock);
        check("t1_rsp_valid_c1", 32'(rsp_valid), 32'd0);
        next_cycle();
        @(negedge clock);
        check("t1_rsp_valid_c2", 32'(rsp_valid), 32'b0001);
        check("t1_rsp_result_c2", rsp_result[0], 32'd7);
        next_cycle();
        @(negedge clock);
        check("t1_rsp_valid_c3", 32'(rsp_valid), 32'd0);
        check("t1_idle_c3", 32'(idle), 32'd1);
        next_cycle();

        // All four requesters SUB 10,i continuously
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, TIA_OP_SUB, 32'd10, 32'(k), 32'(10 - k));
        for (int r = 0; r < 3; r++) for (int k = 0; k < N; k++) gq.push_back(k);
        req_valid = 4'b1111;
        repeat (12) next_cycle();
        req_valid = '0;
        wait_idle(50);
        check("t2_grants_all_seen", 32'(gq.size()), 32'd0);

        // Requester 2 holds its result for 5 cycles
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, TIA_OP_SUB, 32'd10, 32'(k), 32'(10 - k));
        rsp_ready = 4'b1011;
        req_valid = 4'b1111;
        repeat (4) next_cycle();
        for (int h = 0; h < 5; h++) begin
            @(negedge clock);
            check("t3_hold_rsp_valid2", 32'(rsp_valid[2]), 32'd1);
            check("t3_hold_rsp_result2", rsp_result[2], 32'd8);
            check("t3_hold_req_ready2", 32'(req_ready[2]), 32'd0);
            check("t3_hold_others_granted", 32'(|req_ready), 32'd1);
            next_cycle();
        end
        rsp_ready = 4'b1111;
        @(negedge clock);
        check("t3_consume_cycle_ready2", 32'(req_ready[2]), 32'd0);
        next_cycle();
        req_valid = 4'b0100;
        @(negedge clock);
        check("t3_regrant2", 32'(req_ready), 32'b0100);
        next_cycle();
        req_valid = '0;
        wait_idle(50);

        // Pointer at 2 with requests from 1 and 3
        do_reset();
        set_req(1, TIA_OP_ADD, 32'd1, 32'd2, 32'd3);
        gq.push_back(1);
        req_valid = 4'b0010;
        @(negedge clock);
        check("t4_prep_grant1", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = '0;
        wait_idle(50);
        set_req(3, TIA_OP_ADD, 32'd5, 32'd5, 32'd10);
        gq.push_back(3);
        gq.push_back(1);
        req_valid = 4'b1010;
        @(negedge clock);
        check("t4_first_grant3", 32'(req_ready), 32'b1000);
        next_cycle();
        req_valid = 4'b0010;
        @(negedge clock);
        check("t4_then_grant1", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = '0;
        wait_idle(50);

        // Reset the cycle after issuing LMUL 6,7 from requester 1
        do_reset();
        set_req(1, TIA_OP_LMUL, 32'd6, 32'd7, 32'd42);
        req_valid = 4'b0010;
        @(negedge clock);
        check("t5_issue_grant1", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = '0;
        reset     = 1'b1;
        @(negedge clock);
        check("t5_fu_enable_reset", 32'(fu_enable), 32'd0);
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
            check("t5_idle", 32'(idle), 32'd1);
            check("t5_fu_op_nop", 32'(fu_op), 32'(TIA_OP_NOP));
            next_cycle();
        end
        set_req(1, TIA_OP_ADD, 32'd1, 32'd2, 32'd3);
        set_req(3, TIA_OP_ADD, 32'd5, 32'd5, 32'd10);
        req_valid = 4'b1010;
        @(negedge clock);
        check("t5_pointer0_grant1", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = 4'b1000;
        @(negedge clock);
        check("t5_then_grant3", 32'(req_ready), 32'b1000);
        next_cycle();
        req_valid = '0;
        wait_idle(50);

        // No requests for 10 cycles
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("t6_req_ready", 32'(req_ready), 32'd0);
            check("t6_fu_op", 32'(fu_op), 32'(TIA_OP_NOP));
            check("t6_operand_0", fu_operand_0, 32'd0);
            check("t6_operand_1", fu_operand_1, 32'd0);
            check("t6_operand_2", fu_operand_2, 32'd0);
            check("t6_idle", 32'(idle), 32'd1);
            next_cycle();
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("grant_queue_drained", 32'(gq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
